// File: rtl/yung_cheng.sv
// yung_cheng: F = (A xor B) & (C | ~D) with registered copy and a 16-code self-sweep checker.
// Optional debug taps (sweep_vec, sweep_f) are compiled in when YUNG_CHENG_DBG_EN is defined.
//
// state   | meaning
// S_IDLE  | waiting for start; tt/match hold last result
// S_SWEEP | capturing F(cnt) into tt[cnt], cnt 0..15
// S_DONE  | one-cycle done pulse, match valid
module yung_cheng #(
  parameter logic [15:0] EXPECT_TT = 16'h0DD0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  output logic        f,
  output logic        f_q,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic        match
`ifdef YUNG_CHENG_DBG_EN
  ,
  output logic [3:0]  sweep_vec,
  output logic [0:0]  sweep_f
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [15:0] tt_nxt;
  logic        match_nxt;

  function automatic logic eval_f(input logic [3:0] code);
    return (code[3] ^ code[2]) & (code[1] | ~code[0]);
  endfunction

  assign f = (a ^ b) & (c | ~d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q <= 1'b0;
    end else begin
      f_q <= f;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      tt    <= 16'h0000;
      match <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      tt    <= tt_nxt;
      match <= match_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tt_nxt    = tt;
    match_nxt = match;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_SWEEP;
          cnt_nxt   = 4'd0;
          tt_nxt    = 16'h0000;
          match_nxt = 1'b0;
        end
      end
      S_SWEEP: begin
        tt_nxt[cnt] = eval_f(cnt);
        // 15 -> 0 wrap happens only here, on the way out to S_DONE
        cnt_nxt     = cnt + 4'd1;
        if (cnt == 4'd15) begin
          state_nxt = S_DONE;
          match_nxt = (tt_nxt == EXPECT_TT);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign busy = (state == S_SWEEP);
  assign done = (state == S_DONE);

`ifdef YUNG_CHENG_DBG_EN
  // registered alongside the capture so the taps line up with cnt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_vec <= 4'd0;
      sweep_f   <= 1'b0;
    end else if (state_nxt == S_SWEEP) begin
      sweep_vec <= cnt_nxt;
      sweep_f   <= eval_f(cnt_nxt);
    end else begin
      sweep_vec <= 4'd0;
      sweep_f   <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_yung_cheng.sv
// Self-checking bench for yung_cheng: random pins/starts against a behavioural model,
// plus directed sweep, ignored-start, mismatch-signature and mid-sweep reset cases.
module tb_yung_cheng;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic        start = 1'b0;
  logic        f, f_q, busy, done, match;
  logic [15:0] tt;
  logic        f_mm, f_q_mm, busy_mm, done_mm, match_mm;
  logic [15:0] tt_mm;
`ifdef YUNG_CHENG_DBG_EN
  logic [3:0]  sweep_vec, sweep_vec_mm;
  logic [0:0]  sweep_f, sweep_f_mm;
`endif

  yung_cheng dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
    .f(f), .f_q(f_q), .start(start), .busy(busy), .done(done),
    .tt(tt), .match(match)
`ifdef YUNG_CHENG_DBG_EN
    , .sweep_vec(sweep_vec), .sweep_f(sweep_f)
`endif
  );

  yung_cheng #(.EXPECT_TT(16'hFFFF)) dut_mm (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
    .f(f_mm), .f_q(f_q_mm), .start(start), .busy(busy_mm), .done(done_mm),
    .tt(tt_mm), .match(match_mm)
`ifdef YUNG_CHENG_DBG_EN
    , .sweep_vec(sweep_vec_mm), .sweep_f(sweep_f_mm)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference F from the minterm list, not from the gate equation
  function automatic logic ref_f(input int code);
    case (code)
      4, 6, 7, 8, 10, 11: return 1'b1;
      default:            return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] golden();
    logic [15:0] g;
    for (int i = 0; i < 16; i++) g[i] = ref_f(i);
    return g;
  endfunction

  // age: -1 idle, 1..16 sweeping (age-1 bits captured), 17 done pulse
  int          age;
  logic        m_fq;
  logic [15:0] m_last;
  logic        m_match, m_match_mm;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age        <= -1;
      m_fq       <= 1'b0;
      m_last     <= 16'h0000;
      m_match    <= 1'b0;
      m_match_mm <= 1'b0;
    end else begin
      m_fq <= ref_f({28'd0, a, b, c, d});
      if (age >= 1 && age <= 16) begin
        age <= age + 1;
        if (age == 16) begin
          m_last     <= golden();
          m_match    <= (golden() == 16'h0DD0);
          m_match_mm <= (golden() == 16'hFFFF);
        end
      end else if (age == 17) begin
        age <= -1;
      end else if (start) begin
        age        <= 1;
        m_last     <= 16'h0000;
        m_match    <= 1'b0;
        m_match_mm <= 1'b0;
      end
    end
  end

  function automatic logic [15:0] exp_tt(input int ag, input logic [15:0] last);
    logic [16:0] one;
    logic [16:0] mask;
    one = 17'd1;
    if (ag >= 1 && ag <= 16) begin
      mask = (one << (ag - 1)) - 17'd1;
      return golden() & mask[15:0];
    end
    return last;
  endfunction

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("f",        f,        ref_f({28'd0, a, b, c, d}));
      chk("f_q",      f_q,      m_fq);
      chk("busy",     busy,     (age >= 1 && age <= 16));
      chk("done",     done,     (age == 17));
      chk("tt",       tt,       exp_tt(age, m_last));
      chk("match",    match,    m_match);
      chk("tt_mm",    tt_mm,    exp_tt(age, m_last));
      chk("match_mm", match_mm, m_match_mm);
      chk("f_q_mm",   f_q_mm,   m_fq);
`ifdef YUNG_CHENG_DBG_EN
      chk("sweep_vec", sweep_vec, (age >= 1 && age <= 16) ? (age - 1) : 0);
      chk("sweep_f",   sweep_f,   (age >= 1 && age <= 16) ? ref_f(age - 1) : 1'b0);
`endif
    end
  end

  task automatic drive_rand();
    {a, b, c, d} = 4'($urandom_range(0, 15));
  endtask

  // Launch a sweep; optionally re-pulse start restart_at cycles later. Returns done latency or -1.
  task automatic run_sweep(input int restart_at, output int lat);
    int n0;
    lat = -1;
    @(negedge clk); #2;
    start = 1'b1;
    n0 = cyc;
    drive_rand();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done && lat < 0) lat = cyc - n0;
      #2;
      start = (restart_at > 0) && (cyc == n0 + restart_at);
      drive_rand();
    end
    start = 1'b0;
  endtask

  initial begin
    int lat;
    int n0;
    bit saw_done;
    logic [15:0] lit_tt;
    lit_tt = 16'h0DD0;

    repeat (2) @(negedge clk);
    chk("rst_f_q", f_q, 0);
    chk("rst_tt", tt, 16'h0000);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_match", match, 0);
    #3 rst_n = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk); #2;
      {a, b, c, d} = 4'(i);
      #1 chk($sformatf("f_code%0d", i), f, lit_tt[i]);
    end

    run_sweep(0, lat);
    chk("sweep_latency", lat, 17);
    chk("sweep_tt", tt, 16'h0DD0);
    chk("sweep_match", match, 1);
    chk("mm_tt", tt_mm, 16'h0DD0);
    chk("mm_match", match_mm, 0);

    run_sweep(5, lat);
    chk("restart_latency", lat, 17);
    chk("restart_tt", tt, 16'h0DD0);
    chk("restart_match", match, 1);

    // abort a sweep with reset at sweep cycle 8
    @(negedge clk); #2;
    start = 1'b1;
    n0 = cyc;
    @(negedge clk); #2;
    start = 1'b0;
    for (int k = 0; k < 30 && cyc < n0 + 8; k++) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_tt", tt, 16'h0000);
    chk("abort_done", done, 0);
    chk("abort_match", match, 0);
    chk("abort_f_q", f_q, 0);
    @(posedge clk);
    @(negedge clk); #3;
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 0);

    run_sweep(0, lat);
    chk("post_abort_latency", lat, 17);
    chk("post_abort_tt", tt, 16'h0DD0);
    chk("post_abort_match", match, 1);

    for (int k = 0; k < 600; k++) begin
      @(negedge clk); #2;
      drive_rand();
      start = ($urandom_range(0, 7) == 0);
    end
    start = 1'b0;
    repeat (20) @(negedge clk);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
